// File: rtl/fp_mult_pkg.sv
// Shared types for the fp multiplier scheduler.
// Requester ids and in-flight tags travel down the result pipe.
package fp_mult_pkg;

  localparam int FP_W       = 32;
  localparam int NUM_REQ    = 2;
  localparam int INFLIGHT_W = 5;

  typedef logic req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/fp_mult_scheduler_if.sv
// Requester, multiplier and result signals of the scheduler.
// slave is the scheduler side, master the surrounding system.
interface fp_mult_scheduler_if;
  import fp_mult_pkg::*;

  logic            req0_valid;
  logic            req0_ready;
  logic [FP_W-1:0] req0_a;
  logic [FP_W-1:0] req0_b;
  logic            req1_valid;
  logic            req1_ready;
  logic [FP_W-1:0] req1_a;
  logic [FP_W-1:0] req1_b;
  logic            mul_valid;
  logic [FP_W-1:0] mul_op1;
  logic [FP_W-1:0] mul_op2;
  logic [FP_W-1:0] mul_result;
  logic            res0_valid;
  logic            res1_valid;
  logic [FP_W-1:0] res_data;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  mul_result,
    output req0_ready, req1_ready,
    output mul_valid, mul_op1, mul_op2,
    output res0_valid, res1_valid, res_data
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output mul_result,
    input  req0_ready, req1_ready,
    input  mul_valid, mul_op1, mul_op2,
    input  res0_valid, res1_valid, res_data
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; prio moves to the loser on a grant.
// Grants are suppressed while reset is held.
module rr_arbiter2
  import fp_mult_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] i_valid,
  output logic [NUM_REQ-1:0] o_grant
);

  req_id_t r_prio;

  always_comb begin
    o_grant = '0;
    if (!rst) begin
      unique case (i_valid)
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        2'b11:   o_grant = r_prio ? 2'b10 : 2'b01;
        default: o_grant = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else if (|o_grant) begin
      r_prio <= o_grant[0];
    end
  end

endmodule

// File: rtl/fp_mult_scheduler.sv
// Issues operand pairs from two requesters into the shared multiplier
// and routes each result back to its issuer via a tag pipeline.
module fp_mult_scheduler
  import fp_mult_pkg::*;
#(
  parameter int LATENCY = 3
)
(
  input  logic                  clk,
  input  logic                  rst,
  fp_mult_scheduler_if.slave    bus,
  output logic [INFLIGHT_W-1:0] inflight,
  output logic                  busy
);

  logic [NUM_REQ-1:0]    w_grant;
  logic                  w_hs;
  req_id_t               w_id;
  tag_t                  w_tag_out;
  logic                  r_mul_valid;
  logic [FP_W-1:0]       r_op1;
  logic [FP_W-1:0]       r_op2;
  req_id_t               r_iss_id;
  tag_t                  r_tag [LATENCY];
  logic [INFLIGHT_W-1:0] r_inflight;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_valid ({bus.req1_valid, bus.req0_valid}),
    .o_grant (w_grant)
  );

  assign w_hs      = |w_grant;
  assign w_id      = w_grant[1];
  assign w_tag_out = r_tag[LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mul_valid <= 1'b0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_iss_id    <= 1'b0;
      r_inflight  <= '0;
      for (int i = 0; i < LATENCY; i++)
        r_tag[i] <= '0;
    end else begin
      r_mul_valid <= w_hs;
      if (w_hs) begin
        r_op1    <= w_id ? bus.req1_a : bus.req0_a;
        r_op2    <= w_id ? bus.req1_b : bus.req0_b;
        r_iss_id <= w_id;
      end
      r_tag[0] <= '{valid: r_mul_valid, id: r_iss_id};
      for (int i = 1; i < LATENCY; i++)
        r_tag[i] <= r_tag[i-1];
      // issue and retire in one cycle cancel out
      unique case (1'b1)
        (w_hs && !w_tag_out.valid):
          r_inflight <= r_inflight + INFLIGHT_W'(1);
        (!w_hs && w_tag_out.valid):
          r_inflight <= r_inflight - INFLIGHT_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.req0_ready = w_grant[0];
  assign bus.req1_ready = w_grant[1];
  assign bus.mul_valid  = r_mul_valid;
  assign bus.mul_op1    = r_op1;
  assign bus.mul_op2    = r_op2;
  assign bus.res0_valid = w_tag_out.valid && !w_tag_out.id;
  assign bus.res1_valid = w_tag_out.valid && w_tag_out.id;
  assign bus.res_data   = bus.mul_result;
  assign inflight       = r_inflight;
  assign busy           = (r_inflight != '0) || r_mul_valid;

endmodule

// File: tb/tb_fp_mult_scheduler.sv
// Directed bench for fp_mult_scheduler with a table-driven
// multiplier model and an issue-order scoreboard.
module tb_fp_mult_scheduler;
  import fp_mult_pkg::*;

  localparam int L = 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [INFLIGHT_W-1:0] inflight;
  logic                  busy;
  int                    n_chk = 0;
  int                    n_pass = 0;
  int                    cyc = 0;

  fp_mult_scheduler_if bus ();

  fp_mult_scheduler #(.LATENCY(L)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .inflight (inflight),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_mul(
    input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h3FC00000_40000000: return 32'h40400000;
      64'h40000000_40400000: return 32'h40C00000;
      64'h3F800000_3F800000: return 32'h3F800000;
      64'h3F000000_40800000: return 32'h40000000;
      64'hBF800000_40000000: return 32'hC0000000;
      64'h40400000_40400000: return 32'h41100000;
      64'h3FC00000_3FC00000: return 32'h40100000;
      64'h7FC00000_00000001: return 32'h7FC00000;
      default:               return 32'hDEADBEEF;
    endcase
  endfunction

  // multiplier model: fixed L-cycle pipe, keeps running through reset
  logic [31:0] m_pipe [L];
  initial for (int k = 0; k < L; k++) m_pipe[k] = 32'h0;
  always @(posedge clk) begin
    m_pipe[0] <= bus.mul_valid ?
      ref_mul(bus.mul_op1, bus.mul_op2) : 32'h0BAD0000 | cyc[15:0];
    for (int k = 1; k < L; k++) m_pipe[k] <= m_pipe[k-1];
  end
  assign bus.mul_result = m_pipe[L-1];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  logic        q_id [$];
  logic [31:0] q_dat [$];

  always @(negedge clk) begin
    if (rst) begin
      q_id.delete();
      q_dat.delete();
    end else begin
      if (bus.res0_valid || bus.res1_valid) begin
        chk("res_onehot", bus.res0_valid & bus.res1_valid, 0);
        if (q_id.size() == 0) begin
          chk("res_unexpected", 1, 0);
        end else begin
          chk("sb_id", bus.res1_valid, q_id[0]);
          chk("sb_data", bus.res_data, q_dat[0]);
          void'(q_id.pop_front());
          void'(q_dat.pop_front());
        end
      end
      if (bus.req0_valid && bus.req0_ready) begin
        q_id.push_back(1'b0);
        q_dat.push_back(ref_mul(bus.req0_a, bus.req0_b));
      end
      if (bus.req1_valid && bus.req1_ready) begin
        q_id.push_back(1'b1);
        q_dat.push_back(ref_mul(bus.req1_a, bus.req1_b));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, busy, 0);
  endtask

  logic [31:0] s_a [6] = '{32'h3F800000, 32'h3F000000, 32'hBF800000,
                           32'h40400000, 32'h3FC00000, 32'h40000000};
  logic [31:0] s_b [6] = '{32'h3F800000, 32'h40800000, 32'h40000000,
                           32'h40400000, 32'h3FC00000, 32'h40400000};

  initial begin
    int peak, last_res, idle, nres;
    bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0;
    bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0;

    // reset state, readies forced low
    step();
    bus.req0_valid = 1; bus.req1_valid = 1;
    @(negedge clk);
    chk("rst_rdy0", bus.req0_ready, 0);
    chk("rst_rdy1", bus.req1_ready, 0);
    step();
    @(negedge clk);
    chk("rst_mul_valid", bus.mul_valid, 0);
    chk("rst_op1", bus.mul_op1, 0);
    chk("rst_op2", bus.mul_op2, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res0", bus.res0_valid, 0);
    chk("rst_res1", bus.res1_valid, 0);

    // single op
    step();
    rst = 0;
    bus.req1_valid = 0;
    bus.req0_a = 32'h3FC00000; bus.req0_b = 32'h40000000;
    @(negedge clk);
    chk("one_rdy0", bus.req0_ready, 1);
    chk("one_rdy1", bus.req1_ready, 0);
    step();
    bus.req0_valid = 0;
    @(negedge clk);
    chk("one_mul_valid", bus.mul_valid, 1);
    chk("one_op1", bus.mul_op1, 32'h3FC00000);
    chk("one_op2", bus.mul_op2, 32'h40000000);
    chk("one_inflight", inflight, 1);
    chk("one_busy", busy, 1);
    for (int k = 2; k <= L + 1; k++) begin
      @(negedge clk);
      chk("one_res0", bus.res0_valid, k == L + 1);
      chk("one_res1", bus.res1_valid, 0);
      if (k == L + 1) chk("one_data", bus.res_data, 32'h40400000);
    end
    @(negedge clk);
    chk("one_inflight_end", inflight, 0);
    chk("one_busy_end", busy, 0);

    // lone streamer on requester 1
    peak = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      bus.req1_valid = 1; bus.req1_a = s_a[i]; bus.req1_b = s_b[i];
      @(negedge clk);
      chk("lone_rdy1", bus.req1_ready, 1);
      if (int'(inflight) > peak) peak = int'(inflight);
    end
    step();
    bus.req1_valid = 0;
    last_res = -1; idle = -1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (int'(inflight) > peak) peak = int'(inflight);
      if (bus.res1_valid) last_res = j;
      if (!busy) begin
        idle = j;
        break;
      end
    end
    chk("lone_peak", peak, (6 < L + 1) ? 6 : L + 1);
    if (idle < 0) chk("lone_drain_timeout", 1, 0);
    else chk("lone_busy_drop", idle - last_res, 1);

    // contention: alternating grants, inflight saturates at L+1
    for (int i = 0; i < 8; i++) begin
      step();
      bus.req0_valid = 1;
      bus.req0_a = 32'h3FC00000; bus.req0_b = 32'h40000000;
      bus.req1_valid = 1;
      bus.req1_a = 32'h40000000; bus.req1_b = 32'h40400000;
      @(negedge clk);
      chk("cont_rdy0", bus.req0_ready, i % 2 == 0);
      chk("cont_rdy1", bus.req1_ready, i % 2 == 1);
      chk("cont_inflight", inflight, (i < L + 1) ? i : L + 1);
    end
    step();
    bus.req0_valid = 0; bus.req1_valid = 0;
    drain("cont");

    // reset mid-flight
    for (int i = 0; i < 3; i++) begin
      step();
      bus.req0_valid = 1;
      bus.req0_a = 32'h40400000; bus.req0_b = 32'h40400000;
      @(negedge clk);
    end
    step();
    bus.req0_valid = 0;
    rst = 1;
    @(negedge clk);
    step();
    rst = 0;
    @(negedge clk);
    chk("mrst_inflight", inflight, 0);
    chk("mrst_op1", bus.mul_op1, 0);
    chk("mrst_mul_valid", bus.mul_valid, 0);
    nres = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (bus.res0_valid || bus.res1_valid) nres++;
    end
    chk("mrst_no_res", nres, 0);
    chk("mrst_inflight_end", inflight, 0);
    chk("mrst_busy", busy, 0);
    step();
    bus.req0_valid = 1;
    bus.req0_a = 32'h3FC00000; bus.req0_b = 32'h40000000;
    bus.req1_valid = 1;
    bus.req1_a = 32'h40000000; bus.req1_b = 32'h40400000;
    @(negedge clk);
    chk("mrst_prio_rdy0", bus.req0_ready, 1);
    chk("mrst_prio_rdy1", bus.req1_ready, 0);
    step();
    bus.req0_valid = 0; bus.req1_valid = 0;
    drain("mrst");

    // special operands pass through untouched
    step();
    bus.req1_valid = 1;
    bus.req1_a = 32'h7FC00000; bus.req1_b = 32'h00000001;
    @(negedge clk);
    chk("nan_rdy1", bus.req1_ready, 1);
    step();
    bus.req1_valid = 0;
    @(negedge clk);
    chk("nan_mul_valid", bus.mul_valid, 1);
    chk("nan_op1", bus.mul_op1, 32'h7FC00000);
    chk("nan_op2", bus.mul_op2, 32'h00000001);
    idle = -1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (bus.res0_valid || bus.res1_valid) begin
        idle = j;
        chk("nan_res1", bus.res1_valid, 1);
        chk("nan_data", bus.res_data, 32'h7FC00000);
        break;
      end
    end
    if (idle < 0) chk("nan_timeout", 1, 0);
    drain("nan");
    chk("sb_empty", q_id.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
